// File: rtl/uart_echo_ctrl.sv
// ---------------------------------------------------------------------------
// uart_echo_ctrl
//
// Single-clock controller sitting between the UART core's FIFO interface and
// the board I/O. Each word waiting in the RX FIFO is popped, shown on the
// LEDs, transformed according to the selected mode and pushed back into the
// TX FIFO. If the TX FIFO stays full for too long the word in flight is
// dropped so the receive side never stalls indefinitely. RX, TX and drop
// counters are kept for debug display.
//
// Parameters:
//   N_BIT    data word width (matches the UART core)
//   CNT_W    width of each statistics counter (counters wrap)
//   TO_W     width of the TX-full timeout counter
//   TIMEOUT  TX-full wait limit in cycles before the word is dropped
//            (must be representable in TO_W bits)
//
// Ports:
//   CLK        system clock, everything on the rising edge
//   RESET      synchronous, active-high reset
//   mode       transform select: 0 echo, 1 increment, 2 invert,
//              3 receive-only (nothing is transmitted)
//   rx_empty   RX FIFO empty flag
//   r_data     RX FIFO head word, valid while rx_empty is low
//   rd_uart    RX FIFO pop strobe
//   tx_full    TX FIFO full flag
//   wr_uart    TX FIFO push strobe
//   w_data     word offered to the TX FIFO
//   leds       last received word
//   rx_count   words popped from the RX FIFO
//   tx_count   words pushed into the TX FIFO
//   drop_count words dropped because the TX FIFO stayed full
//   busy       high whenever the controller is not idle
// ---------------------------------------------------------------------------
module uart_echo_ctrl #(
    parameter int N_BIT   = 8,
    parameter int CNT_W   = 8,
    parameter int TO_W    = 10,
    parameter int TIMEOUT = 1023
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [1:0]       mode,
    input  logic             rx_empty,
    input  logic [N_BIT-1:0] r_data,
    output logic             rd_uart,
    input  logic             tx_full,
    output logic             wr_uart,
    output logic [N_BIT-1:0] w_data,
    output logic [N_BIT-1:0] leds,
    output logic [CNT_W-1:0] rx_count,
    output logic [CNT_W-1:0] tx_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_POP  = 2'b01,
        ST_PUSH = 2'b10
    } state_t;

    localparam logic [1:0]      MODE_ECHO = 2'd0;
    localparam logic [1:0]      MODE_INC  = 2'd1;
    localparam logic [1:0]      MODE_INV  = 2'd2;
    localparam logic [1:0]      MODE_RXO  = 2'd3;
    localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT);

    // Transform applied to a received word before it is sent back.
    // Receive-only mode never transmits, so its value is irrelevant and the
    // raw word is passed through.
    function automatic logic [N_BIT-1:0] xform(
        input logic [N_BIT-1:0] d,
        input logic [1:0]       m
    );
        logic [N_BIT-1:0] r;
        case (m)
            MODE_ECHO: r = d;
            MODE_INC:  r = d + N_BIT'(1);
            MODE_INV:  r = ~d;
            default:   r = d;
        endcase
        return r;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic             to_inc_s;
    logic [TO_W-1:0]  to_cnt_r;
    logic [N_BIT-1:0] w_data_r;
    logic [N_BIT-1:0] leds_r;
    logic [CNT_W-1:0] rx_cnt_r;
    logic [CNT_W-1:0] tx_cnt_r;
    logic [CNT_W-1:0] drop_cnt_r;

    // Next-state decode and FIFO strobes from the registered state and the
    // current FIFO flags only.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        push_s      = 1'b0;
        drop_s      = 1'b0;
        to_inc_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rx_empty) begin
                    state_nxt_s = ST_POP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_POP: begin
                // The pop is gated on a non-empty FIFO so a strobe can never
                // reach an empty FIFO even if the flag misbehaves.
                if (!rx_empty) begin
                    pop_s = 1'b1;
                    if (mode == MODE_RXO) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_PUSH;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PUSH: begin
                if (!tx_full) begin
                    push_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (to_cnt_r == TO_LIMIT) begin
                    drop_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    to_inc_s    = 1'b1;
                    state_nxt_s = ST_PUSH;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, data-path and statistics registers; reset overrides every event.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r    <= ST_IDLE;
            to_cnt_r   <= {TO_W{1'b0}};
            w_data_r   <= {N_BIT{1'b0}};
            leds_r     <= {N_BIT{1'b0}};
            rx_cnt_r   <= {CNT_W{1'b0}};
            tx_cnt_r   <= {CNT_W{1'b0}};
            drop_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (pop_s) begin
                // The transform is resolved with the mode seen at pop time,
                // so later mode changes cannot alter the word in flight.
                leds_r   <= r_data;
                w_data_r <= xform(r_data, mode);
                rx_cnt_r <= rx_cnt_r + CNT_W'(1);
                to_cnt_r <= {TO_W{1'b0}};
            end
            if (to_inc_s) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end
            if (push_s) begin
                tx_cnt_r <= tx_cnt_r + CNT_W'(1);
            end
            if (drop_s) begin
                drop_cnt_r <= drop_cnt_r + CNT_W'(1);
            end
        end
    end

    assign rd_uart    = pop_s;
    assign wr_uart    = push_s;
    assign w_data     = w_data_r;
    assign leds       = leds_r;
    assign rx_count   = rx_cnt_r;
    assign tx_count   = tx_cnt_r;
    assign drop_count = drop_cnt_r;
    assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_echo_ctrl
//
// Bench for uart_echo_ctrl. A queue models the RX FIFO feeding the design;
// each word carries the mode that is presented while it sits at the head.
// When a word is issued its expected response (raw word, transformed word,
// whether it is transmitted) is pushed into a scoreboard queue. A monitor on
// the falling edge tracks the design's service rules at transaction level
// (when a pop is due, how long a word may wait on a full TX FIFO) and
// compares strobes, data, LEDs, busy and counters every cycle.
// ---------------------------------------------------------------------------
module tb_uart_echo_ctrl;

    localparam int N_BIT   = 8;
    localparam int CNT_W   = 8;
    localparam int TO_W    = 10;
    localparam int TIMEOUT = 6;

    logic             CLK = 1'b0;
    logic             RESET;
    logic [1:0]       mode;
    logic             rx_empty;
    logic [N_BIT-1:0] r_data;
    logic             rd_uart;
    logic             tx_full;
    logic             wr_uart;
    logic [N_BIT-1:0] w_data;
    logic [N_BIT-1:0] leds;
    logic [CNT_W-1:0] rx_count;
    logic [CNT_W-1:0] tx_count;
    logic [CNT_W-1:0] drop_count;
    logic             busy;

    uart_echo_ctrl #(
        .N_BIT  (N_BIT),
        .CNT_W  (CNT_W),
        .TO_W   (TO_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .mode      (mode),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd_uart   (rd_uart),
        .tx_full   (tx_full),
        .wr_uart   (wr_uart),
        .w_data    (w_data),
        .leds      (leds),
        .rx_count  (rx_count),
        .tx_count  (tx_count),
        .drop_count(drop_count),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] raw;
        logic [1:0] md;
    } rxw_t;

    typedef struct {
        logic [7:0] raw;
        logic [7:0] out;
        bit         tx;
    } exp_t;

    rxw_t       rx_q[$];
    exp_t       exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [1:0] idle_mode = 2'd0;
    bit         pop_flag = 1'b0;
    int         full_len = 0;

    // Reference transform, written as plain arithmetic on integers.
    function automatic logic [7:0] ref_xform(input logic [7:0] d, input logic [1:0] m);
        int v;
        case (m)
            2'd1:    v = (int'(d) + 1) % 256;
            2'd2:    v = 255 - int'(d);
            default: v = int'(d);
        endcase
        return 8'(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        rx_empty = (rx_q.size() == 0);
        if (rx_q.size() > 0) begin
            r_data = rx_q[0].raw;
            mode   = rx_q[0].md;
        end else begin
            r_data = 8'h00;
            mode   = idle_mode;
        end
    endtask

    // Advance one cycle; the FIFO pop requested by the monitor is applied
    // just after the edge at which the design captured the head word.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (pop_flag) begin
            if (rx_q.size() > 0) void'(rx_q.pop_front());
            pop_flag = 1'b0;
        end
        drive_fifo();
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] m);
        rxw_t w;
        exp_t e;
        w.raw = d;
        w.md  = m;
        e.raw = d;
        e.out = ref_xform(d, m);
        e.tx  = (m != 2'd3);
        rx_q.push_back(w);
        exp_q.push_back(e);
        drive_fifo();
    endtask

    task automatic drain(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (rx_q.size() == 0 && exp_q.size() == 0 && busy === 1'b0) done = 1'b1;
        end
        if (!done) check("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic rand_tick();
        if (full_len == 0 && $urandom_range(0, 39) == 0) full_len = $urandom_range(3, 12);
        if (full_len > 0) begin
            tx_full  = 1'b1;
            full_len = full_len - 1;
        end else begin
            tx_full = ($urandom_range(0, 7) == 0);
        end
        idle_mode = 2'($urandom_range(0, 3));
        tick();
    endtask

    // Monitor / reference model state
    bit         m_pending = 1'b0;
    int         m_wait = 0;
    logic [7:0] m_out = 8'h00;
    int         m_rx = 0;
    int         m_tx = 0;
    int         m_drop = 0;
    logic [7:0] m_leds = 8'h00;
    bit         prev_idle = 1'b0;
    bit         prev_nonempty = 1'b0;
    bit         exp_rd;
    bit         pend_now;
    exp_t       e_pop;

    always @(negedge CLK) begin
        if (RESET === 1'b1) begin
            if (rd_uart === 1'b1) begin
                pop_flag = 1'b1;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            m_pending     = 1'b0;
            m_wait        = 0;
            m_rx          = 0;
            m_tx          = 0;
            m_drop        = 0;
            m_leds        = 8'h00;
            prev_idle     = 1'b0;
            prev_nonempty = !rx_empty;
        end else begin
            pend_now = m_pending;
            exp_rd   = prev_idle && prev_nonempty;
            check("rd_uart", rd_uart, exp_rd);
            check("wr_uart", wr_uart, pend_now && !tx_full);
            check("busy", busy, exp_rd || pend_now);
            check("rx_count", rx_count, m_rx % 256);
            check("tx_count", tx_count, m_tx % 256);
            check("drop_count", drop_count, m_drop % 256);
            check("leds", leds, m_leds);
            if (pend_now) begin
                if (!tx_full) begin
                    if (wr_uart === 1'b1) check("w_data", w_data, m_out);
                    m_tx++;
                    m_pending = 1'b0;
                end else if (m_wait == TIMEOUT) begin
                    m_drop++;
                    m_pending = 1'b0;
                end else begin
                    m_wait++;
                end
            end
            if (exp_rd) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    e_pop  = exp_q.pop_front();
                    m_rx++;
                    m_leds = e_pop.raw;
                    if (e_pop.tx) begin
                        m_pending = 1'b1;
                        m_wait    = 0;
                        m_out     = e_pop.out;
                    end
                end
            end
            if (rd_uart === 1'b1) pop_flag = 1'b1;
            prev_idle     = !exp_rd && !pend_now;
            prev_nonempty = !rx_empty;
        end
    end

    initial begin
        RESET   = 1'b1;
        tx_full = 1'b0;
        drive_fifo();
        repeat (2) tick();
        RESET = 1'b0;
        tick();

        // Plain echo
        send(8'h35, 2'd0);
        drain(50);
        check("t1_rx", rx_count, 32'd1);
        check("t1_tx", tx_count, 32'd1);
        check("t1_leds", leds, 32'h35);

        // Increment with wrap, back-to-back, then invert
        send(8'hFF, 2'd1);
        send(8'h41, 2'd1);
        drain(50);
        send(8'h0F, 2'd2);
        drain(50);
        check("t2_rx", rx_count, 32'd4);
        check("t2_tx", tx_count, 32'd4);

        // Receive-only
        send(8'h11, 2'd3);
        send(8'h22, 2'd3);
        send(8'h33, 2'd3);
        drain(50);
        check("t3_rx", rx_count, 32'd7);
        check("t3_tx", tx_count, 32'd4);
        check("t3_leds", leds, 32'h33);

        // Stall on full TX FIFO for 5 push cycles, mode changed meanwhile
        tx_full   = 1'b1;
        idle_mode = 2'd2;
        send(8'hA5, 2'd0);
        repeat (7) tick();
        tx_full = 1'b0;
        drain(50);
        check("t4_drop", drop_count, 32'd0);
        check("t4_tx", tx_count, 32'd5);

        // Timeout drop, then normal service resumes
        tx_full = 1'b1;
        send(8'h5A, 2'd1);
        drain(50);
        check("t5_drop", drop_count, 32'd1);
        check("t5_tx", tx_count, 32'd5);
        tx_full = 1'b0;
        send(8'h10, 2'd0);
        drain(50);
        check("t5_tx_after", tx_count, 32'd6);

        // Reset in the middle of a stalled push
        tx_full = 1'b1;
        send(8'h77, 2'd0);
        repeat (4) tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("t6_busy", busy, 32'd0);
        check("t6_wr", wr_uart, 32'd0);
        check("t6_rx", rx_count, 32'd0);
        check("t6_tx", tx_count, 32'd0);
        check("t6_drop", drop_count, 32'd0);
        check("t6_leds", leds, 32'd0);
        tx_full = 1'b0;
        tick();

        // Random traffic, enough words to wrap the counters
        for (int w = 0; w < 300; w++) begin
            send(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
            repeat ($urandom_range(1, 4)) rand_tick();
        end
        tx_full  = 1'b0;
        full_len = 0;
        drain(5000);
        check("rand_rx_wrap", rx_count, 32'd44);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_echo_ctrl.md
Name: uart_echo_ctrl

Overview:
Clocked controller between the UART core's FIFO interface (rx_empty/rd_uart/r_data, tx_full/wr_uart/w_data) and board I/O.
- Pops each received word, shows it on LEDs and applies a selectable transform.
- Pushes the result back to the TX FIFO with flow control and a timeout-based drop.
- Keeps RX, TX and drop counters for debug display.
- Replaces ad-hoc edge-triggered echo logic with a single-clock FSM.

Parameters:
N_BIT, 8, data word width (matches UART N_BIT)
CNT_W, 8, width of each statistics counter
TO_W, 10, width of the TX-full timeout counter
TIMEOUT, 1023, cycles spent waiting on tx_full before the held word is dropped (must be < 2^TO_W)

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
mode  in  2  transform select: 0 echo, 1 increment, 2 bitwise invert, 3 receive-only (no TX)
rx_empty  in  1  UART RX FIFO empty
r_data  in  N_BIT  RX FIFO head word (valid while rx_empty=0)
rd_uart  out  1  RX FIFO pop strobe
tx_full  in  1  UART TX FIFO full
wr_uart  out  1  TX FIFO push strobe
w_data  out  N_BIT  word to TX FIFO
leds  out  N_BIT  last received word
rx_count  out  CNT_W  words popped
tx_count  out  CNT_W  words pushed
drop_count  out  CNT_W  words dropped on timeout
busy  out  1  high when state != IDLE

Behaviour:
- Reset (synchronous, RESET high at a rising edge): state=IDLE; hold, leds, w_data, all counters, timeout counter, latched mode = 0. rd_uart=wr_uart=0 in the cycle after reset. Reset wins over every other event, including mid-PUSH: the held word is discarded and no counter increments.
- States: IDLE, POP, PUSH. Register state; rd_uart and wr_uart are decoded from registered state and inputs only, with no feedback loops.
- IDLE:
  - rx_empty=0 -> POP next cycle.
  - Otherwise stay in IDLE.
- POP (exactly 1 cycle):
  - rd_uart=1.
  - hold<=r_data, leds<=r_data, mode_q<=mode, rx_count<=rx_count+1, to_cnt<=0.
  - mode==3 -> IDLE; else -> PUSH.
- PUSH:
  - w_data is continuously driven with the transform of hold:
    - mode_q 0: hold.
    - mode_q 1: hold+1 mod 2^N_BIT (8'hFF -> 8'h00).
    - mode_q 2: ~hold.
  - tx_full=0: wr_uart=1 this cycle, tx_count+1, -> IDLE.
  - tx_full=1 and to_cnt==TIMEOUT: wr_uart=0, drop_count+1, -> IDLE.
  - Otherwise: to_cnt+1, stay in PUSH.
- Mode changes after POP do not affect the word in flight; only mode_q is used.
- Latency: rx_empty falls at edge k -> rd_uart high in cycle k+1 -> wr_uart high in cycle k+2 when tx_full=0. Best-case throughput is 1 word per 3 cycles; in mode 3 it is 1 word per 2 cycles.
- Back-to-back: after PUSH/POP returns to IDLE, a still-nonempty RX FIFO is served at the next cycle; no word is skipped or popped twice.
- Counters wrap modulo 2^CNT_W, with no saturation.
- rd_uart is never asserted while rx_empty=1. wr_uart is never asserted while tx_full=1. The two are never high in the same cycle.
- busy = (state != IDLE).

Test Plan:
1. Reset, mode=0, RX FIFO presents 8'h35 (rx_empty falls) -> rd_uart pulses 1 cycle, leds=8'h35, next cycle wr_uart=1 with w_data=8'h35; rx_count=tx_count=1.
2. mode=1, receive 8'hFF then 8'h41 back-to-back -> w_data 8'h00 then 8'h42, each pop exactly once, rx_count=2, tx_count=2. Repeat with mode=2 on 8'h0F -> 8'hF0.
3. mode=3, receive 3 words -> wr_uart never asserted, leds holds the last word, rx_count=3, tx_count=0, each word takes 2 cycles.
4. mode=0, tx_full=1 held for 5 cycles then released -> wr_uart asserts on the first cycle tx_full=0, drop_count=0; mode switched to 2 during the stall -> transmitted word is unchanged (echo).
5. TIMEOUT=4, tx_full held high -> after 5 PUSH cycles the FSM returns to IDLE, drop_count=1, wr_uart never high; the next RX word is still processed normally.
6. Assert RESET during PUSH with tx_full=1 -> next cycle state=IDLE, all counters and leds=0, no wr_uart; also check rd_uart never asserts with rx_empty=1 across 256 random-traffic words and that counters wrap at 256.
